hex_btn_io: RTL

- Parametrised Avalon-MM slave replacing the fixed 4-button PIO and six 7-bit HEX PIOs in the HPS/FPGA system.
- Drives NUM_HEX active-low seven-segment digits with optional hex decode, blanking and per-digit blink.
- Debounces NUM_BTN active-low push-buttons, captures press edges, and raises a level IRQ to the HPS.

---
 rtl/hex_btn_io_pkg.sv | 58 +++++
 rtl/hex_btn_io_if.sv | 21 ++
 rtl/hex_btn_io_debounce.sv | 59 +++++
 rtl/hex_btn_io.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/hex_btn_io_pkg.sv
// hex_btn_io_pkg: register map, CTRL layout, DIGIT field positions and the
// seven-segment glyph decoder shared by the hex_btn_io block.
package hex_btn_io_pkg;

  // Word offsets of the register map
  localparam int ADDR_CTRL       = 0;
  localparam int ADDR_BTN_STATE  = 1;
  localparam int ADDR_EDGE_CAP   = 2;
  localparam int ADDR_BLINK_MASK = 3;
  localparam int ADDR_DIGIT_BASE = 4;

  // CTRL bit indices
  localparam int CTRL_DECODE   = 0;
  localparam int CTRL_BLINK_EN = 1;
  localparam int CTRL_IRQ_EN   = 2;
  localparam int CTRL_W        = 3;

  // DIGIT register fields
  localparam int DIGIT_RAW_W  = 7;
  localparam int DIGIT_NIB_W  = 4;
  localparam int DIGIT_BLANK  = 7;
  localparam int DIGIT_W      = 8;
  localparam logic [DIGIT_W-1:0] DIGIT_RESET = 8'h80;

  // Dimmer level register
  localparam int DIM_W = 4;
  localparam logic [DIM_W-1:0] DIM_RESET = 4'hF;

  // CTRL as a packed struct; member order matches the bit indices above
  typedef struct packed {
    logic irq_en;    // bit 2
    logic blink_en;  // bit 1
    logic decode;    // bit 0
  } ctrl_t;

  // Nibble to segment pattern, bit0 = seg a ... bit6 = seg g, 1 = lit
  function automatic logic [DIGIT_RAW_W-1:0] hexdecode(input logic [DIGIT_NIB_W-1:0] nib);
    case (nib)
      4'h0:    hexdecode = 7'h3F;
      4'h1:    hexdecode = 7'h06;
      4'h2:    hexdecode = 7'h5B;
      4'h3:    hexdecode = 7'h4F;
      4'h4:    hexdecode = 7'h66;
      4'h5:    hexdecode = 7'h6D;
      4'h6:    hexdecode = 7'h7D;
      4'h7:    hexdecode = 7'h07;
      4'h8:    hexdecode = 7'h7F;
      4'h9:    hexdecode = 7'h6F;
      4'hA:    hexdecode = 7'h77;
      4'hB:    hexdecode = 7'h7C;
      4'hC:    hexdecode = 7'h39;
      4'hD:    hexdecode = 7'h5E;
      4'hE:    hexdecode = 7'h79;
      default: hexdecode = 7'h71;
    endcase
  endfunction

endpackage

// File: rtl/hex_btn_io_if.sv
// hex_btn_io_if: Avalon-MM slave bus bundle (no waitrequest, fixed
// 1-cycle read latency).
interface hex_btn_io_if #(
  parameter int ADDR_W = 5
) ();
  logic [ADDR_W-1:0] avs_address;
  logic              avs_read;
  logic              avs_write;
  logic [31:0]       avs_writedata;
  logic [31:0]       avs_readdata;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata
  );
endinterface

// File: rtl/hex_btn_io_debounce.sv
// hex_btn_debounce: one push-button path. Two-flop synchroniser, inversion
// to active-high, and a stability counter that accepts a new level after
// DEBOUNCE_CYCLES consecutive cycles of disagreement with the accepted state.
module hex_btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn_n,
  output logic o_state,
  output logic o_rise
);
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             w_level;
  logic             w_differ;
  logic             w_accept;

  assign w_level  = ~r_sync2;
  assign w_differ = w_level ^ r_state;
  assign w_accept = w_differ && (r_cnt == CNT_LAST);

  // Synchronise the raw button; reset to "released" so no phantom press
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value; blocking here would collapse the 2-FF chain.
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_btn_n;
      r_sync2 <= r_sync1;
    end
  end

  // Count cycles of disagreement; any agreement restarts the count
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_state <= 1'b0;
    end else if (!w_differ) begin
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_cnt   <= '0;
      r_state <= w_level;
    end else begin
      r_cnt   <= r_cnt + 1'b1;
    end
  end

  assign o_state = r_state;
  assign o_rise  = w_accept & w_level;

endmodule

// File: rtl/hex_btn_io.sv
// hex_btn_io: Avalon-MM slave driving NUM_HEX active-low seven-segment
// digits (hex decode, blank, blink) and debouncing NUM_BTN active-low
// buttons with press-edge capture and a level IRQ.
// Optional feature: define HEX_BTN_IO_DIMMER_EN to add a DIM register at
// offset 4+NUM_HEX and a 16-step PWM brightness control.
module hex_btn_io
  import hex_btn_io_pkg::*;
#(
  parameter int NUM_HEX         = 6,
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int BLINK_DIV       = 12500000,
  parameter int ADDR_W          = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  hex_btn_io_if.slave          avs,
  input  logic [NUM_BTN-1:0]   buttons_n,
  output logic [NUM_HEX*7-1:0] hex_n,
  output logic                 irq
);
  localparam int BLINK_W = $clog2(BLINK_DIV);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  localparam logic [ADDR_W-1:0] A_CTRL  = ADDR_W'(ADDR_CTRL);
  localparam logic [ADDR_W-1:0] A_BTN   = ADDR_W'(ADDR_BTN_STATE);
  localparam logic [ADDR_W-1:0] A_EDGE  = ADDR_W'(ADDR_EDGE_CAP);
  localparam logic [ADDR_W-1:0] A_MASK  = ADDR_W'(ADDR_BLINK_MASK);

  ctrl_t                r_ctrl;
  logic [NUM_HEX-1:0]   r_blink_mask;
  logic [DIGIT_W-1:0]   r_digit [NUM_HEX];
  logic [NUM_BTN-1:0]   r_edge;
  logic                 r_irq;
  logic [31:0]          r_readdata;
  logic [NUM_HEX*7-1:0] r_hex_n;
  logic [BLINK_W-1:0]   r_blink_cnt;
  logic                 r_phase;

  logic [ADDR_W-1:0]    w_addr;
  logic [31:0]          w_wdata;
  logic [31:0]          w_rdata;
  logic [NUM_BTN-1:0]   w_btn_state;
  logic [NUM_BTN-1:0]   w_btn_rise;
  logic [NUM_BTN-1:0]   w_w1c;
  logic [NUM_HEX-1:0]   w_dark;
  logic [NUM_HEX*7-1:0] w_hex_n;
  logic                 w_pwm_off;
  logic                 w_unused;

  assign w_addr   = avs.avs_address;
  assign w_wdata  = avs.avs_writedata;
  // Upper write-data bits have no destination in any register
  assign w_unused = ^w_wdata;

  for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
    hex_btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk     (clk),
      .reset   (reset),
      .i_btn_n (buttons_n[b]),
      .o_state (w_btn_state[b]),
      .o_rise  (w_btn_rise[b])
    );
  end

`ifdef HEX_BTN_IO_DIMMER_EN
  localparam logic [ADDR_W-1:0] A_DIM = ADDR_W'(ADDR_DIGIT_BASE + NUM_HEX);

  logic [DIM_W-1:0] r_dim;
  logic [DIM_W-1:0] r_pwm;

  // DIM level register
  always_ff @(posedge clk) begin
    if (reset)                               r_dim <= DIM_RESET;
    else if (avs.avs_write && w_addr == A_DIM) r_dim <= w_wdata[DIM_W-1:0];
  end

  // Free-running PWM counter
  always_ff @(posedge clk) begin
    if (reset) r_pwm <= '0;
    else       r_pwm <= r_pwm + 1'b1;
  end

  assign w_pwm_off = (r_pwm > r_dim);
`else
  assign w_pwm_off = 1'b0;
`endif

  // Control, blink mask and digit registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctrl       <= '0;
      r_blink_mask <= '0;
      // NOTE: the digit array is a handful of flops with a defined
      // power-up value (blanked), not a RAM, so it is reset explicitly.
      for (int i = 0; i < NUM_HEX; i++) r_digit[i] <= DIGIT_RESET;
    end else if (avs.avs_write) begin
      if (w_addr == A_CTRL) r_ctrl       <= ctrl_t'(w_wdata[CTRL_W-1:0]);
      if (w_addr == A_MASK) r_blink_mask <= w_wdata[NUM_HEX-1:0];
      for (int i = 0; i < NUM_HEX; i++)
        if (w_addr == ADDR_W'(ADDR_DIGIT_BASE + i)) r_digit[i] <= w_wdata[DIGIT_W-1:0];
    end
  end

  assign w_w1c = (avs.avs_write && w_addr == A_EDGE) ? w_wdata[NUM_BTN-1:0] : '0;

  // Edge capture: new presses are ORed in after the clear so a set wins
  always_ff @(posedge clk) begin
    if (reset) r_edge <= '0;
    else       r_edge <= (r_edge & ~w_w1c) | w_btn_rise;
  end

  // Registered level interrupt
  always_ff @(posedge clk) begin
    if (reset) r_irq <= 1'b0;
    else       r_irq <= r_ctrl.irq_en & (|r_edge);
  end

  // Blink prescaler; parked at zero while blinking is disabled
  always_ff @(posedge clk) begin
    if (reset || !r_ctrl.blink_en) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
    end else if (r_blink_cnt == BLINK_LAST) begin
      r_blink_cnt <= '0;
      r_phase     <= ~r_phase;
    end else begin
      r_blink_cnt <= r_blink_cnt + 1'b1;
    end
  end

  // Segment selection and darkening per digit
  always_comb begin
    // NOTE: defaults first so every path assigns every bit; otherwise the
    // tool infers latches for the unassigned cases.
    w_hex_n = '1;
    w_dark  = '0;
    for (int i = 0; i < NUM_HEX; i++) begin
      w_dark[i] = r_digit[i][DIGIT_BLANK]
                | (r_ctrl.blink_en & r_blink_mask[i] & r_phase)
                | w_pwm_off;
      w_hex_n[7*i +: 7] = w_dark[i] ? 7'h7F
                        : ~(r_ctrl.decode ? hexdecode(r_digit[i][DIGIT_NIB_W-1:0])
                                          : r_digit[i][DIGIT_RAW_W-1:0]);
    end
  end

  // Output register for the segment drive
  always_ff @(posedge clk) begin
    if (reset) r_hex_n <= '1;
    else       r_hex_n <= w_hex_n;
  end

  // Read mux; unmapped offsets and unused bits return zero
  always_comb begin
    w_rdata = '0;
    if (w_addr == A_CTRL) w_rdata[CTRL_W-1:0]  = r_ctrl;
    if (w_addr == A_BTN)  w_rdata[NUM_BTN-1:0] = w_btn_state;
    if (w_addr == A_EDGE) w_rdata[NUM_BTN-1:0] = r_edge;
    if (w_addr == A_MASK) w_rdata[NUM_HEX-1:0] = r_blink_mask;
    for (int i = 0; i < NUM_HEX; i++)
      if (w_addr == ADDR_W'(ADDR_DIGIT_BASE + i)) w_rdata[DIGIT_W-1:0] = r_digit[i];
`ifdef HEX_BTN_IO_DIMMER_EN
    if (w_addr == A_DIM) w_rdata[DIM_W-1:0] = r_dim;
`endif
  end

  // Registered read data, valid the cycle after avs_read
  always_ff @(posedge clk) begin
    if (reset) r_readdata <= '0;
    else       r_readdata <= avs.avs_read ? w_rdata : '0;
  end

  assign avs.avs_readdata = r_readdata;
  assign hex_n            = r_hex_n;
  assign irq              = r_irq;

endmodule
